// File: rtl/mem_lsu.sv
// Load/store unit between the MEM stage and a word-only, 1-cycle-read data memory.
// Byte/half stores become read-modify-write sequences; loads are aligned and extended here.
module mem_lsu #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WAIT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [29:0] wordIdx_q, wordIdx_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] wdata_q, wdata_d;

  logic        funct3Legal;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic        isWordStore;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;
  logic [31:0] merged;

  always_comb begin
    funct3Legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3Legal = 1'b1;
      3'b100, 3'b101:         funct3Legal = !req_we;
      default:                funct3Legal = 1'b0;
    endcase
    misaligned  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    outOfRange  = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    reqErr      = !funct3Legal || misaligned || outOfRange;
    isWordStore = req_we && (req_funct3 == 3'b010);
  end

  // Lane extraction for loads and lane replacement for the RMW write both use the latched offset.
  always_comb begin
    byteSel = dmem_rd[{off_q, 3'b000} +: 8];
    halfSel = dmem_rd[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  loadExt = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadExt = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadExt = {24'h000000, byteSel};
      3'b101:  loadExt = {16'h0000, halfSel};
      default: loadExt = dmem_rd;
    endcase
    merged = dmem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    access_err = 1'b0;
    dmem_we    = 1'b0;
    dmem_a     = {wordIdx_q, 2'b00};
    dmem_wd    = req_wdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reqErr) begin
            access_err = 1'b1;
          end else begin
            dmem_a    = {req_addr[31:2], 2'b00};
            wordIdx_d = req_addr[31:2];
            if (isWordStore) begin
              dmem_we = 1'b1;
            end else begin
              stall    = 1'b1;
              off_d    = req_addr[1:0];
              funct3_d = req_funct3;
              wdata_d  = req_wdata[15:0];
              state_d  = req_we ? RMW_WAIT : LOAD_WAIT;
            end
          end
        end
      end
      LOAD_WAIT: begin
        load_valid = 1'b1;
        load_data  = loadExt;
        state_d    = IDLE;
      end
      RMW_WAIT: begin
        dmem_we = 1'b1;
        dmem_wd = merged;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wordIdx_q <= 30'h0;
      off_q     <= 2'b00;
      funct3_q  <= 3'b000;
      wdata_q   <= 16'h0;
    end else begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level reference memory predicts every cycle,
// and literal checks pin the model on the documented scenarios.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_err;
  logic        dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  always #5 clk = ~clk;

  mem_lsu #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
    .access_err (access_err),
    .dmem_we    (dmem_we),
    .dmem_a     (dmem_a),
    .dmem_wd    (dmem_wd),
    .dmem_rd    (dmem_rd)
  );

  // Word-write memory with synchronous read; a bench-side port preloads contents.
  logic [31:0] sram [64];
  logic        preWe = 1'b0;
  logic [5:0]  preIdx = 6'd0;
  logic [31:0] preVal = 32'h0;

  always @(posedge clk) begin
    if (preWe) sram[preIdx] <= preVal;
    else if (dmem_we && dmem_a[31:8] == 24'h0) sram[dmem_a[7:2]] <= dmem_wd;
    dmem_rd <= (dmem_a[31:8] == 24'h0) ? sram[dmem_a[7:2]] : 32'h0;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem [64];
  logic        cmpEn = 1'b0;
  logic        expStall, expLv, expErr, expWe;
  logic [31:0] expA, expLd, expWd;
  logic [31:0] lastA = 32'h0;
  logic [31:0] lastLoad = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("stall", {31'h0, stall}, {31'h0, expStall});
      checkOutput("load_valid", {31'h0, load_valid}, {31'h0, expLv});
      checkOutput("access_err", {31'h0, access_err}, {31'h0, expErr});
      checkOutput("dmem_we", {31'h0, dmem_we}, {31'h0, expWe});
      checkOutput("dmem_a", dmem_a, expA);
      if (expLv) checkOutput("load_data", load_data, expLd);
      if (expWe) checkOutput("dmem_wd", dmem_wd, expWd);
      if (load_valid) lastLoad = load_data;
    end
  end

  function automatic logic modelErr(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    int   size;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    size  = 1 << f3[1:0];
    return !legal || ((addr % size) != 0) || ((addr / 4) >= 64);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v;
    v = word >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  task automatic clearExp();
    expStall = 1'b0; expLv = 1'b0; expErr = 1'b0; expWe = 1'b0;
    expA = lastA; expLd = 32'h0; expWd = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      clearExp();
      tick();
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    req_valid = 1'b0;
    preWe = 1'b1; preIdx = 6'(idx); preVal = val;
    refMem[idx] = val;
    clearExp();
    tick();
    preWe = 1'b0;
  endtask

  // Drives one request for as many cycles as the reference behaviour says it occupies.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
    int          wi;
    logic [31:0] old;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wi = int'(addr / 4);
    clearExp();
    if (modelErr(we, f3, addr)) begin
      expErr = 1'b1;
      tick();
    end else if (we && f3 == 3'd2) begin
      lastA = addr & 32'hFFFF_FFFC;
      expWe = 1'b1; expA = lastA; expWd = wd;
      refMem[wi] = wd;
      tick();
    end else begin
      lastA = addr & 32'hFFFF_FFFC;
      expStall = 1'b1; expA = lastA;
      tick();
      clearExp();
      old = refMem[wi];
      if (!we) begin
        expLv = 1'b1; expLd = modelLoad(old, f3, addr[1:0]);
      end else begin
        expWe = 1'b1; expWd = modelMerge(old, f3, addr[1:0], wd);
        refMem[wi] = expWd;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    clearExp();
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst stall", {31'h0, stall}, 32'h0);
    checkOutput("rst load_valid", {31'h0, load_valid}, 32'h0);
    checkOutput("rst access_err", {31'h0, access_err}, 32'h0);
    checkOutput("rst dmem_we", {31'h0, dmem_we}, 32'h0);
    checkOutput("rst dmem_a", dmem_a, 32'h0);
    checkOutput("rst load_data", load_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    cmpEn = 1'b1;

    for (int i = 0; i < 64; i++) preload(i, 32'h0);

    // SW then LW of the same word
    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
    checkOutput("t1 lw", lastLoad, 32'hDEADBEEF);
    idle(2);

    preload(8, 32'h11223344);
    applyStimulus(1'b1, 3'd0, 32'h21, 32'h000000AA);
    applyStimulus(1'b0, 3'd4, 32'h21, 32'h0);
    checkOutput("t2 lbu", lastLoad, 32'h000000AA);
    applyStimulus(1'b0, 3'd0, 32'h21, 32'h0);
    checkOutput("t2 lb", lastLoad, 32'hFFFFFFAA);
    checkOutput("t2 word", sram[8], 32'h1122AA44);

    preload(12, 32'h80007FFF);
    applyStimulus(1'b0, 3'd1, 32'h32, 32'h0);
    checkOutput("t3 lh", lastLoad, 32'hFFFF8000);
    applyStimulus(1'b0, 3'd5, 32'h32, 32'h0);
    checkOutput("t3 lhu", lastLoad, 32'h00008000);
    applyStimulus(1'b1, 3'd1, 32'h30, 32'hCAFE1234);
    applyStimulus(1'b0, 3'd2, 32'h30, 32'h0);
    checkOutput("t3 sh", lastLoad, 32'h80001234);

    // Error classes, then the last legal word
    applyStimulus(1'b0, 3'd2, 32'h13, 32'h0);
    applyStimulus(1'b1, 3'd1, 32'h11, 32'h5555);
    applyStimulus(1'b1, 3'd2, 32'h100, 32'h77777777);
    applyStimulus(1'b0, 3'd3, 32'h10, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h10, 32'h66);
    applyStimulus(1'b0, 3'd5, 32'h33, 32'h0);
    idle(1);
    checkOutput("t4 word", sram[4], 32'hDEADBEEF);
    applyStimulus(1'b1, 3'd2, 32'hFC, 32'h0BADF00D);
    applyStimulus(1'b0, 3'd2, 32'hFC, 32'h0);
    checkOutput("t4 last word", lastLoad, 32'h0BADF00D);

    // Reset while the RMW write is pending
    preload(8, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'hAA;
    lastA = 32'h20;
    clearExp();
    expStall = 1'b1;
    tick();
    cmpEn = 1'b0;
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("t5 dmem_we", {31'h0, dmem_we}, 32'h0);
    checkOutput("t5 stall", {31'h0, stall}, 32'h0);
    checkOutput("t5 dmem_a", dmem_a, 32'h0);
    checkOutput("t5 load_valid", {31'h0, load_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    lastA = 32'h0;
    cmpEn = 1'b1;
    idle(2);
    checkOutput("t5 word", sram[8], 32'h11223344);

    // Back-to-back byte stores into one word, then a word load
    applyStimulus(1'b1, 3'd0, 32'h40, 32'h1234565A);
    applyStimulus(1'b1, 3'd0, 32'h41, 32'hFFFFFFC3);
    applyStimulus(1'b0, 3'd2, 32'h40, 32'h0);
    checkOutput("t6 lw", lastLoad, 32'h0000C35A);
    idle(2);

    cmpEn = 1'b0;
    for (int i = 0; i < 64; i++) checkOutput($sformatf("mem[%0d]", i), sram[i], refMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
